// File: rtl/apb_req_bridge_pkg.sv
// apb_req_bridge shared types and defaults.
// State encoding, default widths and the zero response-data constant.
package apb_req_bridge_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 255;

  // read data returned for writes and aborted transfers
  localparam int unsigned RSP_ZERO = 0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/apb_req_timeout.sv
// apb_req_timeout: ACCESS wait counter for apb_req_bridge.
// Cleared on clr, counts on en, flags expire at LIMIT.
module apb_req_timeout #(
  parameter int unsigned LIMIT = 255,
  localparam int unsigned CW =
    (LIMIT < 1) ? 1 : $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CW-1:0] cnt;

  assign expire = (cnt == CW'(LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/apb_req_bridge.sv
// apb_req_bridge: single-outstanding request stream to APB bridge.
// Define APB_REQ_BRIDGE_TIMEOUT_EN to abort stalled ACCESS phases.
module apb_req_bridge
  import apb_req_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  input  logic              i_req_write,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_err,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [ADDR_W-1:0] o_paddr,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready,
  input  logic              i_pslverr
);

  state_t state;
  logic   tmo_expire;

`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
  apb_req_timeout #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (i_clk),
    .rst_n  (i_rstn),
    .clr    (state == SETUP),
    .en     ((state == ACCESS) && !i_pready),
    .expire (tmo_expire)
  );
`else
  logic unused_tmo;
  assign unused_tmo = |TIMEOUT_CYC;
  assign tmo_expire = 1'b0;
`endif

  // APB address/data registers double as the request capture
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= IDLE;
      o_req_ready <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_err   <= 1'b0;
      o_psel      <= 1'b0;
      o_penable   <= 1'b0;
      o_pwrite    <= 1'b0;
      o_paddr     <= '0;
      o_pwdata    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          o_req_ready <= 1'b1;
          if (i_req_valid && o_req_ready) begin
            o_paddr     <= i_req_addr;
            o_pwdata    <= i_req_wdata;
            o_pwrite    <= i_req_write;
            o_psel      <= 1'b1;
            o_req_ready <= 1'b0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          o_penable <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (i_pready) begin
            o_psel      <= 1'b0;
            o_penable   <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= i_pslverr;
            o_rsp_data  <= o_pwrite ?
                           DATA_W'(RSP_ZERO) : i_prdata;
            state       <= RESP;
          end else if (tmo_expire) begin
            o_psel      <= 1'b0;
            o_penable   <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
            o_rsp_data  <= DATA_W'(RSP_ZERO);
            state       <= RESP;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_req_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_bridge.sv
// tb_apb_req_bridge: random transfers vs a per-transfer timeline model.
// Covers APB_REQ_BRIDGE_TIMEOUT_EN builds with TIMEOUT_CYC=4.
module tb_apb_req_bridge;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_write;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  apb_req_bridge #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .i_req_write (req_write),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_err   (rsp_err),
    .o_psel      (psel),
    .o_penable   (penable),
    .o_pwrite    (pwrite),
    .o_paddr     (paddr),
    .o_pwdata    (pwdata),
    .i_prdata    (prdata),
    .i_pready    (pready),
    .i_pslverr   (pslverr)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready;
    int k = 0;
    while (!req_ready && k < 8) begin
      tick();
      k++;
    end
    check("req_ready_wait", req_ready, 1);
  endtask

  // d: ACCESS cycles with pready low before completion
  // b: response cycles with rsp_ready low
  task automatic run_txn(input logic wr,
                         input logic [31:0] addr,
                         input logic [31:0] wdata,
                         input logic [31:0] rdata,
                         input logic slverr,
                         input int d,
                         input int b);
    int de, last, rs;
    logic [31:0] edata;
    logic eerr;
    de    = d;
    eerr  = slverr;
    edata = wr ? 32'h0 : rdata;
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
    if (d > TMO) begin
      de    = TMO;
      eerr  = 1'b1;
      edata = 32'h0;
    end
`endif
    rs   = 3 + de;
    last = 4 + de + b;
    wait_ready();
    req_valid = 1'b1;
    req_addr  = addr;
    req_wdata = wdata;
    req_write = wr;
    tick();
    for (int c = 1; c <= last; c++) begin
      check("psel", psel, c <= 2 + de);
      check("penable", penable, c >= 2 && c <= 2 + de);
      check("rsp_valid", rsp_valid,
            c >= rs && c <= rs + b);
      check("req_ready", req_ready, c == last);
      check("paddr", paddr, addr);
      check("pwdata", pwdata, wdata);
      check("pwrite", pwrite, wr);
      if (c >= rs && c <= rs + b) begin
        check("rsp_data", rsp_data, edata);
        check("rsp_err", rsp_err, eerr);
      end
      req_valid = (c < last) ? 1'($urandom_range(0, 1)) : 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_write = 1'($urandom_range(0, 1));
      pready    = (c == 2 + d) && (c <= 2 + de);
      prdata    = (c == 2 + d) ? rdata : $urandom;
      pslverr   = (c == 2 + d) ? slverr
                               : 1'($urandom_range(0, 1));
      rsp_ready = (c < rs) ? 1'($urandom_range(0, 1))
                           : (c == rs + b);
      if (c < last) tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_write = 1'b0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;

    #12;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    #10 rstn = 1'b1;
    tick();
    check("idle_ready", req_ready, 1);

    run_txn(1'b0, 32'h10, $urandom, 32'hCAFEF00D, 1'b0, 0, 0);
    run_txn(1'b1, 32'h20, 32'h12345678, $urandom, 1'b0, 3, 0);
    run_txn(1'b0, 32'h30, $urandom, 32'hDEADBEEF, 1'b1, 1, 0);
    run_txn(1'b0, 32'h34, $urandom, 32'h00C0FFEE, 1'b0, 0, 0);
    run_txn(1'b0, 32'h40, $urandom, 32'h55AA55AA, 1'b0, 0, 5);

    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom,
              $urandom, 1'($urandom_range(0, 1)),
              $urandom_range(0, 6), $urandom_range(0, 3));
    end

`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
    run_txn(1'b0, 32'h50, $urandom, $urandom, 1'b0, 1000, 1);
    run_txn(1'b1, 32'h54, $urandom, $urandom, 1'b0, TMO, 0);
`endif

    wait_ready();
    req_valid = 1'b1;
    req_addr  = 32'h60;
    req_wdata = 32'hA5A5A5A5;
    req_write = 1'b0;
    tick();
    req_valid = 1'b0;
    pready    = 1'b0;
    tick();
    check("pre_rst_access", psel & penable, 1);
`ifndef APB_REQ_BRIDGE_TIMEOUT_EN
    for (int i = 0; i < 300; i++) begin
      tick();
      check("hang_access", psel & penable & ~rsp_valid, 1);
    end
`endif
    #3 rstn = 1'b0;
    pready = 1'b1;
    #1;
    check("mid_rst_psel", psel, 0);
    check("mid_rst_penable", penable, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_paddr", paddr, 0);
    #12;
    pready = 1'b0;
    rstn   = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("post_rst_ready", req_ready, 1);
      check("post_rst_rsp_valid", rsp_valid, 0);
      check("post_rst_psel", psel, 0);
      tick();
    end
    run_txn(1'b0, 32'h70, $urandom, 32'h13572468, 1'b0, 2, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_req_bridge.md
# apb_req_bridge

Request-to-APB bridge sitting directly upstream of the APB slave: it accepts single read/write requests on a valid/ready stream from the core-side master and converts each into one APB SETUP/ACCESS transfer. It returns read data and error status on a valid/ready response channel. Exactly one transfer is outstanding at a time; no buffering beyond one request and one response.

## Interface
Parameters:
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- TIMEOUT_CYC, 255, maximum ACCESS wait cycles before abort; only used with the timeout feature

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset; asynchronous assert, active-low
- i_req_valid  in  1  request present
- o_req_ready  out  1  bridge can accept a request
- i_req_addr  in  ADDR_W  request address
- i_req_wdata  in  DATA_W  write data
- i_req_write  in  1  1 = write, 0 = read
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  consumer accepts response
- o_rsp_data  out  DATA_W  read data; 0 for writes
- o_rsp_err  out  1  PSLVERR or timeout
- o_psel  out  1  APB select
- o_penable  out  1  APB enable
- o_pwrite  out  1  APB direction
- o_paddr  out  ADDR_W  APB address
- o_pwdata  out  DATA_W  APB write data
- i_prdata  in  DATA_W  APB read data
- i_pready  in  1  APB ready
- i_pslverr  in  1  APB slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state IDLE.
- IDLE: o_req_ready=1. On i_req_valid&&o_req_ready, register addr/wdata/write, go SETUP.
- SETUP: o_psel=1, o_penable=0, paddr/pwdata/pwrite driven from registers; unconditionally go ACCESS.
- ACCESS: o_psel=1, o_penable=1, APB outputs held stable. On i_pready=1: capture o_rsp_data = write ? 0 : i_prdata, o_rsp_err = i_pslverr, go RESP.
- RESP: o_rsp_valid=1, o_psel=o_penable=0; data/err held stable until i_rsp_ready=1, then go IDLE.
- o_req_ready is 0 in every state except IDLE; no new request accepted in the response handshake cycle.
- o_paddr/o_pwdata/o_pwrite keep last value outside SETUP/ACCESS (no toggling when idle).
- Reset mid-transfer: all outputs return to reset values immediately; in-flight request and response are dropped, no response produced.
- Reset values: o_req_ready=0 while i_rstn low, 1 in IDLE after release; o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, o_psel=0, o_penable=0, o_pwrite=0, o_paddr=0, o_pwdata=0.

## Timing
- Request accepted cycle N; SETUP cycle N+1; ACCESS from N+2; pready=1 at N+2 gives o_rsp_valid at N+3.
- With i_rsp_ready=1, IDLE again at N+4: minimum 4 cycles per transfer.
- Each ACCESS cycle with i_pready=0 adds one cycle of latency.
- All outputs registered or decoded from state register only; no combinational path from i_req_valid, i_pready or i_rsp_ready to any output.

## Configuration
- APB_REQ_BRIDGE_TIMEOUT_EN defined: counter of width $clog2(TIMEOUT_CYC+1) cleared on SETUP, incremented each ACCESS cycle with i_pready=0. When count equals TIMEOUT_CYC and i_pready=0, transfer aborts: go RESP with o_rsp_err=1, o_rsp_data=0. i_pready=1 in the same cycle as expiry wins (normal completion).
- Undefined: no counter; ACCESS waits indefinitely for i_pready.

## Structure
- Package apb_req_bridge_pkg: state enum type (IDLE, SETUP, ACCESS, RESP), default widths, response-data-on-error constant (0).
- One sub-module: apb_req_timeout (timeout counter with clear/enable/expire), instantiated only under APB_REQ_BRIDGE_TIMEOUT_EN.

## Test plan
- Read, addr 0x0000_0010, pready=1 first ACCESS cycle, prdata 0xCAFE_F00D -> psel high N+1..N+2, penable at N+2, rsp_valid N+3 with data 0xCAFE_F00D, err 0.
- Write, addr 0x20, wdata 0x1234_5678, pready low 3 cycles -> pwdata/paddr stable throughout ACCESS, rsp at N+6, data 0, err 0.
- Read with pslverr=1 at completion -> rsp_err=1, data = i_prdata sampled; next request accepted normally.
- Response backpressure: i_rsp_ready low 5 cycles -> rsp_valid, data, err held; o_req_ready stays 0 until handshake+1.
- Timeout (macro on, TIMEOUT_CYC=4), pready never asserted -> abort after 4 ACCESS cycles, rsp_err=1, data 0, psel dropped; macro off -> psel held for 300 cycles with no response.
- i_rstn low during ACCESS -> psel, penable, rsp_valid low immediately; after release bridge in IDLE with o_req_ready=1 and no stray response.
